// File: rtl/half_duplex_bus_ctrl_if.sv
// Request/response and status signals between user logic and the
// half-duplex bus sequencer; the board-level pins stay a separate inout.
interface half_duplex_bus_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ack;
  logic             rd_req;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             busy;
  logic             bus_dir;
  logic             bus_oe;

  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_ack, rd_data, rd_valid, busy, bus_dir, bus_oe
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_ack, rd_data, rd_valid, busy, bus_dir, bus_oe
  );
endinterface

// File: rtl/half_duplex_bus_ctrl.sv
// Half-duplex bus sequencer: owns the tristate, drives only in TX and
// inserts released-bus guard cycles whenever the bus direction flips.
module half_duplex_bus_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned TURN_CYC = 2,
  parameter int unsigned TX_HOLD  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  half_duplex_bus_ctrl_if.slave ctrl,
  inout  wire  [WIDTH-1:0]      bus_io
);

  localparam int unsigned MAX_CNT = (TURN_CYC > TX_HOLD) ? TURN_CYC : TX_HOLD;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(TX_HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TURN_TX = 3'd1,
    TX      = 3'd2,
    TURN_RX = 3'd3,
    RX      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ack_q, wr_ack_d;
  logic             rd_valid_q, rd_valid_d;
  logic             take_wr, take_rd;

  // On a simultaneous request, the one matching the current direction wins
  assign take_wr = ctrl.wr_req && (!ctrl.rd_req || dir_q);
  assign take_rd = ctrl.rd_req && !take_wr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= '0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      rd_data_q  <= rd_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    tx_d       = tx_q;
    rd_data_d  = rd_data_q;
    wr_ack_d   = 1'b0;
    rd_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A still-held request must not be re-accepted in its ack/valid cycle
        if (!wr_ack_q && !rd_valid_q) begin
          if (take_wr) begin
            tx_d = ctrl.wr_data;
            if (dir_q || (TURN_CYC == 0)) begin
              state_d = TX;
              dir_d   = 1'b1;
              cnt_d   = HOLD_LOAD;
            end else begin
              state_d = TURN_TX;
              cnt_d   = TURN_LOAD;
            end
          end else if (take_rd) begin
            if (!dir_q || (TURN_CYC == 0)) begin
              state_d = RX;
              dir_d   = 1'b0;
            end else begin
              state_d = TURN_RX;
              cnt_d   = TURN_LOAD;
            end
          end
        end
      end
      TURN_TX: begin
        if (cnt_q == '0) begin
          state_d = TX;
          dir_d   = 1'b1;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TX: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          wr_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TURN_RX: begin
        if (cnt_q == '0) begin
          state_d = RX;
          dir_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX: begin
        state_d    = IDLE;
        rd_data_d  = bus_io;
        rd_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    oe_d   = (state_d == TX);
    busy_d = (state_d != IDLE);
  end

  assign bus_io        = oe_q ? tx_q : {WIDTH{1'bz}};
  assign ctrl.wr_ack   = wr_ack_q;
  assign ctrl.rd_data  = rd_data_q;
  assign ctrl.rd_valid = rd_valid_q;
  assign ctrl.busy     = busy_q;
  assign ctrl.bus_dir  = dir_q;
  assign ctrl.bus_oe   = oe_q;

endmodule

// File: tb/tb_half_duplex_bus_ctrl.sv
// Bench for half_duplex_bus_ctrl: directed cycle table, mid-transfer reset,
// and random traffic against a transaction-timeline reference model.
module tb_half_duplex_bus_ctrl;

  localparam int unsigned W    = 8;
  localparam int          TURN = 2;
  localparam int          HOLD = 1;
  localparam int          NRND = 3000;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] far_d;
  wire  [W-1:0] bus;

  int n_chk  = 0;
  int n_pass = 0;

  half_duplex_bus_ctrl_if #(.WIDTH(W)) bif ();

  half_duplex_bus_ctrl #(.WIDTH(W), .TURN_CYC(TURN), .TX_HOLD(HOLD)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ctrl   (bif),
    .bus_io (bus)
  );

  // Far end drives whenever the controller has released the bus
  assign bus = bif.bus_oe ? {W{1'bz}} : far_d;

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  typedef struct {
    logic         chk;
    logic         rst, wr, rd;
    logic [W-1:0] wd, fd;
    logic         e_busy, e_dir, e_oe, e_ack, e_val;
    logic [W-1:0] e_rd, e_bus;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic r, input logic w, input logic q,
                              input logic [W-1:0] wd, input logic [W-1:0] fd,
                              input logic b, input logic d, input logic o, input logic a,
                              input logic v, input logic [W-1:0] rdd, input logic [W-1:0] bs);
    vec_t t;
    t.chk = c; t.rst = r; t.wr = w; t.rd = q; t.wd = wd; t.fd = fd;
    t.e_busy = b; t.e_dir = d; t.e_oe = o; t.e_ack = a; t.e_val = v;
    t.e_rd = rdd; t.e_bus = bs;
    return t;
  endfunction

  function automatic void check_outs(input string tag, input logic b, input logic d,
                                     input logic o, input logic a, input logic v,
                                     input logic [W-1:0] rdd, input logic [W-1:0] bs);
    chk({tag, ".busy"},     W'(bif.busy),     W'(b));
    chk({tag, ".bus_dir"},  W'(bif.bus_dir),  W'(d));
    chk({tag, ".bus_oe"},   W'(bif.bus_oe),   W'(o));
    chk({tag, ".wr_ack"},   W'(bif.wr_ack),   W'(a));
    chk({tag, ".rd_valid"}, W'(bif.rd_valid), W'(v));
    chk({tag, ".rd_data"},  bif.rd_data,      rdd);
    chk({tag, ".bus"},      bus,              bs);
  endfunction

  // Reference model: one transfer in flight, described by the cycles it occupies
  int           m_acc, m_free, m_ack_at, m_val_at, m_rx_at, m_tx_s, m_tx_e, m_chg;
  logic         m_dir_old, m_dir_new;
  logic [W-1:0] m_rd_old, m_rd_new, m_tx_d;

  function automatic void model_reset();
    m_acc = -1; m_free = 0; m_ack_at = -1; m_val_at = -1; m_rx_at = -1;
    m_tx_s = 1; m_tx_e = 0; m_chg = 0;
    m_dir_old = 1'b0; m_dir_new = 1'b0;
    m_rd_old = '0; m_rd_new = '0; m_tx_d = '0;
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; bif.wr_req = 1'b0; bif.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit found;
    bit wr_pend, rd_pend;
    logic e_dir, e_busy, e_oe, e_ack, e_val, do_wr, do_rd;
    logic [W-1:0] e_rd, e_bus;
    int t;

    rst = 1'b1; far_d = '0;
    bif.wr_req = 1'b0; bif.rd_req = 1'b0; bif.wr_data = '0;

    //            chk rst wr rd wd     fd      busy dir oe ack val rd_data bus
    tbl.push_back(mk(0, 1, 0, 0, 8'h00, 8'hE0, 0, 0, 0, 0, 0, 8'h00, 8'hE0));
    tbl.push_back(mk(1, 1, 0, 0, 8'h00, 8'hE1, 0, 0, 0, 0, 0, 8'h00, 8'hE1));
    tbl.push_back(mk(1, 0, 1, 0, 8'hA5, 8'hE1, 0, 0, 0, 0, 0, 8'h00, 8'hE1));
    tbl.push_back(mk(1, 0, 1, 0, 8'h5A, 8'hE2, 1, 0, 0, 0, 0, 8'h00, 8'hE2));
    tbl.push_back(mk(1, 0, 1, 0, 8'h5A, 8'hE3, 1, 0, 0, 0, 0, 8'h00, 8'hE3));
    tbl.push_back(mk(1, 0, 1, 0, 8'h5A, 8'hE4, 1, 1, 1, 0, 0, 8'h00, 8'hA5));
    tbl.push_back(mk(1, 0, 1, 0, 8'h5A, 8'hE5, 0, 1, 0, 1, 0, 8'h00, 8'hE5));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h3C, 0, 1, 0, 0, 0, 8'h00, 8'h3C));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h3C, 1, 1, 0, 0, 0, 8'h00, 8'h3C));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h3C, 1, 1, 0, 0, 0, 8'h00, 8'h3C));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h3C, 1, 0, 0, 0, 0, 8'h00, 8'h3C));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h11, 0, 0, 0, 0, 1, 8'h3C, 8'h11));
    // Back-to-back writes, request held across the first ack
    tbl.push_back(mk(1, 0, 1, 0, 8'h01, 8'h12, 0, 0, 0, 0, 0, 8'h3C, 8'h12));
    tbl.push_back(mk(1, 0, 1, 0, 8'h01, 8'h13, 1, 0, 0, 0, 0, 8'h3C, 8'h13));
    tbl.push_back(mk(1, 0, 1, 0, 8'h01, 8'h14, 1, 0, 0, 0, 0, 8'h3C, 8'h14));
    tbl.push_back(mk(1, 0, 1, 0, 8'h02, 8'h15, 1, 1, 1, 0, 0, 8'h3C, 8'h01));
    tbl.push_back(mk(1, 0, 1, 0, 8'h02, 8'h16, 0, 1, 0, 1, 0, 8'h3C, 8'h16));
    tbl.push_back(mk(1, 0, 1, 0, 8'h02, 8'h17, 0, 1, 0, 0, 0, 8'h3C, 8'h17));
    tbl.push_back(mk(1, 0, 1, 0, 8'hF0, 8'h18, 1, 1, 1, 0, 0, 8'h3C, 8'h02));
    tbl.push_back(mk(1, 0, 0, 0, 8'hF0, 8'h19, 0, 1, 0, 1, 0, 8'h3C, 8'h19));
    // Both requests with bus_dir=1: write first, then turnaround and read
    tbl.push_back(mk(1, 0, 1, 1, 8'h77, 8'h20, 0, 1, 0, 0, 0, 8'h3C, 8'h20));
    tbl.push_back(mk(1, 0, 1, 1, 8'h77, 8'h21, 1, 1, 1, 0, 0, 8'h3C, 8'h77));
    tbl.push_back(mk(1, 0, 1, 1, 8'h77, 8'h22, 0, 1, 0, 1, 0, 8'h3C, 8'h22));
    tbl.push_back(mk(1, 0, 0, 1, 8'h77, 8'hC3, 0, 1, 0, 0, 0, 8'h3C, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'hC3, 1, 1, 0, 0, 0, 8'h3C, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'hC3, 1, 1, 0, 0, 0, 8'h3C, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'hC3, 1, 0, 0, 0, 0, 8'h3C, 8'hC3));
    tbl.push_back(mk(1, 0, 0, 1, 8'h00, 8'h27, 0, 0, 0, 0, 1, 8'hC3, 8'h27));
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h28, 0, 0, 0, 0, 0, 8'hC3, 8'h28));

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst = tbl[i].rst; bif.wr_req = tbl[i].wr; bif.rd_req = tbl[i].rd;
      bif.wr_data = tbl[i].wd; far_d = tbl[i].fd;
      @(negedge clk);
      if (tbl[i].chk)
        check_outs($sformatf("row%0d", i), tbl[i].e_busy, tbl[i].e_dir, tbl[i].e_oe,
                   tbl[i].e_ack, tbl[i].e_val, tbl[i].e_rd, tbl[i].e_bus);
    end

    // Reset while driving: bus released next cycle and the write is never acked
    @(posedge clk); #1;
    bif.wr_req = 1'b1; bif.wr_data = 8'h99; far_d = 8'h5E;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bif.bus_oe) begin found = 1'b1; break; end
    end
    chk("midrst.tx_reached", W'(found), W'(1'b1));
    if (found) begin
      chk("midrst.tx_bus", bus, 8'h99);
      rst = 1'b1; bif.wr_req = 1'b0;
      @(negedge clk);
      check_outs("midrst.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5E);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("midrst.no_ack", W'(bif.wr_ack), W'(1'b0));
        chk("midrst.idle", W'(bif.busy), W'(1'b0));
      end
    end

    // Random traffic against the reference model
    apply_reset();
    model_reset();
    wr_pend = 1'b0; rd_pend = 1'b0;
    for (int c = 0; c < NRND; c++) begin
      if (c != 0) begin @(posedge clk); #1; end
      if (!wr_pend && ($urandom_range(3) == 0)) wr_pend = 1'b1;
      if (!rd_pend && ($urandom_range(3) == 0)) rd_pend = 1'b1;
      bif.wr_req  = wr_pend;
      bif.rd_req  = rd_pend;
      bif.wr_data = W'($urandom);
      far_d       = W'($urandom);
      @(negedge clk);

      if (c == m_rx_at) m_rd_new = far_d;
      e_dir  = (c >= m_chg) ? m_dir_new : m_dir_old;
      e_busy = (c > m_acc) && (c < m_free);
      e_oe   = (c >= m_tx_s) && (c <= m_tx_e);
      e_ack  = (c == m_ack_at);
      e_val  = (c == m_val_at);
      e_rd   = (c >= m_val_at) ? m_rd_new : m_rd_old;
      e_bus  = e_oe ? m_tx_d : far_d;
      check_outs("rnd", e_busy, e_dir, e_oe, e_ack, e_val, e_rd, e_bus);

      if ((c >= m_free) && !e_ack && !e_val) begin
        do_wr = bif.wr_req && (!bif.rd_req || e_dir);
        do_rd = bif.rd_req && !do_wr;
        if (do_wr) begin
          t = e_dir ? 0 : TURN;
          m_tx_d = bif.wr_data;
          m_tx_s = c + 1 + t;
          m_tx_e = m_tx_s + HOLD - 1;
          m_ack_at = m_tx_e + 1;
          m_free = m_ack_at;
          m_acc = c;
          m_dir_old = e_dir; m_dir_new = 1'b1; m_chg = m_tx_s;
        end else if (do_rd) begin
          t = e_dir ? TURN : 0;
          m_rx_at = c + 1 + t;
          m_val_at = m_rx_at + 1;
          m_free = m_val_at;
          m_acc = c;
          m_rd_old = e_rd;
          m_dir_old = e_dir; m_dir_new = 1'b0; m_chg = m_rx_at;
        end
      end

      if (bif.wr_ack) wr_pend = 1'b0;
      if (bif.rd_valid) rd_pend = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
